mac_address_table: RTL

MAC_ADDRESS_TABLE -- requirements
Module: mac_address_table

---
 rtl/mac_address_table_pkg.sv | 33 +++
 rtl/mac_address_table_ram.sv | 36 +++
 rtl/mac_address_table.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mac_address_table_pkg.sv
// Shared switch-fabric types plus the MAC table row entry and row hash.
package mac_address_table_pkg;

  typedef logic [11:0] vlan_t;
  typedef logic [47:0] macaddr_t;
  typedef logic [4:0]  port_t;

  // I/G bit of the first octet; set means group (multicast/broadcast) address.
  localparam int unsigned GROUP_BIT = 40;

  typedef struct packed {
    macaddr_t mac;
    vlan_t    vlan;
    port_t    port;
  } mac_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } age_state_t;

  // XOR-fold of the six MAC bytes, vlan[7:0] and zero-extended vlan[11:8];
  // callers truncate to the row-index width.
  function automatic logic [7:0] mac_hash(input vlan_t vlan, input macaddr_t mac);
    logic [7:0] h;
    h = vlan[7:0] ^ {4'b0000, vlan[11:8]};
    for (int i = 0; i < 6; i++) begin
      h = h ^ mac[8*i +: 8];
    end
    return h;
  endfunction

endpackage

// File: rtl/mac_address_table_ram.sv
// Entry storage: one write port, two synchronous read ports, write-first
// bypass so a read of the row being written returns the new entry.
module mac_address_table_ram
  import mac_address_table_pkg::*;
#(
  parameter int TABLE_ROWS = 256,
  parameter int AW         = $clog2(TABLE_ROWS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  mac_entry_t    wdata,
  input  logic [AW-1:0] raddr_a,
  output mac_entry_t    rdata_a,
  input  logic [AW-1:0] raddr_b,
  output mac_entry_t    rdata_b
);

  mac_entry_t mem [TABLE_ROWS];

  // Array write; contents are left uninitialized, valid bits live elsewhere.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port A with same-row write bypass.
  always_ff @(posedge clk) begin
    rdata_a <= (we && (waddr == raddr_a)) ? wdata : mem[raddr_a];
  end

  // Read port B with same-row write bypass.
  always_ff @(posedge clk) begin
    rdata_b <= (we && (waddr == raddr_b)) ? wdata : mem[raddr_b];
  end

endmodule

// File: rtl/mac_address_table.sv
// Direct-mapped MAC/VLAN learning table: 2-edge lookup pipeline, source
// learning one edge after sampling, and a background aging sweep.
//
// Aging sweep states:
//   state | meaning
//   IDLE  | waiting for the next age tick
//   SWEEP | visiting one row per cycle, 0 .. TABLE_ROWS-1
module mac_address_table
  import mac_address_table_pkg::*;
#(
  parameter int TABLE_ROWS      = 256,
  parameter int TOTAL_PORTS     = 28,
  parameter int AGE_TICK_CYCLES = 156250000
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     lookup_en,
  input  vlan_t    lookup_src_vlan,
  input  macaddr_t lookup_src_mac,
  input  port_t    lookup_src_port,
  input  macaddr_t lookup_dst_mac,
  output logic     lookup_hit,
  output port_t    lookup_dst_port,
  output logic     lookup_done,
  input  logic     flush
);

  localparam int AW = $clog2(TABLE_ROWS);
  localparam int PW = (AGE_TICK_CYCLES > 1) ? $clog2(AGE_TICK_CYCLES) : 1;

  typedef logic [AW-1:0] idx_t;

  idx_t dst_idx, src_idx;
  assign dst_idx = idx_t'(mac_hash(lookup_src_vlan, lookup_dst_mac));
  assign src_idx = idx_t'(mac_hash(lookup_src_vlan, lookup_src_mac));

  // Request captured at the sampling edge; RAM rows arrive alongside it.
  logic     s1_valid, s1_flush;
  vlan_t    s1_vlan;
  macaddr_t s1_src_mac, s1_dst_mac;
  port_t    s1_src_port;
  idx_t     s1_dst_idx, s1_src_idx;

  mac_entry_t dst_rd, src_rd, learn_entry;

  logic [TABLE_ROWS-1:0]      valid_q;
  logic [TABLE_ROWS-1:0][1:0] age_q;

  logic       dst_match, src_same_key, learn_ok, learn_wr;
  logic       age_tick, sweep_active;
  logic [PW-1:0] presc_q;
  age_state_t state_q, state_d;
  idx_t       ptr_q, ptr_d;

  mac_address_table_ram #(.TABLE_ROWS(TABLE_ROWS), .AW(AW)) u_ram (
    .clk     (clk),
    .we      (learn_wr),
    .waddr   (s1_src_idx),
    .wdata   (learn_entry),
    .raddr_a (dst_idx),
    .rdata_a (dst_rd),
    .raddr_b (src_idx),
    .rdata_b (src_rd)
  );

  // Capture stage: a lookup sampled under reset or never sampled leaves no trace.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_flush    <= 1'b0;
      s1_vlan     <= '0;
      s1_src_mac  <= '0;
      s1_dst_mac  <= '0;
      s1_src_port <= '0;
      s1_dst_idx  <= '0;
      s1_src_idx  <= '0;
    end else begin
      s1_valid    <= lookup_en;
      s1_flush    <= flush;
      s1_vlan     <= lookup_src_vlan;
      s1_src_mac  <= lookup_src_mac;
      s1_dst_mac  <= lookup_dst_mac;
      s1_src_port <= lookup_src_port;
      s1_dst_idx  <= dst_idx;
      s1_src_idx  <= src_idx;
    end
  end

  // Hit and learn decisions against the rows read at the sampling edge.
  always_comb begin
    dst_match    = s1_valid && !s1_dst_mac[GROUP_BIT] && valid_q[s1_dst_idx] &&
                   (dst_rd.mac == s1_dst_mac) && (dst_rd.vlan == s1_vlan);
    src_same_key = valid_q[s1_src_idx] && (src_rd.mac == s1_src_mac) &&
                   (src_rd.vlan == s1_vlan);
    learn_ok     = s1_valid && !s1_flush && !s1_src_mac[GROUP_BIT] &&
                   (int'(s1_src_port) < TOTAL_PORTS);
    learn_wr     = learn_ok && !flush && !(src_same_key && (src_rd.port == s1_src_port));
    learn_entry  = '{mac: s1_src_mac, vlan: s1_vlan, port: s1_src_port};
  end

  // Result registers hold until the next completed lookup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lookup_hit      <= 1'b0;
      lookup_dst_port <= '0;
      lookup_done     <= 1'b0;
    end else begin
      lookup_done <= s1_valid;
      if (s1_valid) begin
        lookup_hit      <= dst_match;
        lookup_dst_port <= dst_match ? dst_rd.port : '0;
      end
    end
  end

  // Valid/age flops; flush beats everything, learn/refresh beats the sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      age_q   <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      if (sweep_active) begin
        if (age_q[ptr_q] == 2'd0) valid_q[ptr_q] <= 1'b0;
        else                      age_q[ptr_q]   <= age_q[ptr_q] - 2'd1;
      end
      if (learn_ok) begin
        valid_q[s1_src_idx] <= 1'b1;
        age_q[s1_src_idx]   <= 2'd3;
      end
    end
  end

  assign age_tick = (presc_q == PW'(AGE_TICK_CYCLES - 1));

  // Free-running age prescaler.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) presc_q <= '0;
    else     presc_q <= age_tick ? '0 : presc_q + PW'(1);
  end

  // Sweep state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Sweep next state; ticks during SWEEP are dropped.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    sweep_active = 1'b0;
    if (flush) begin
      state_d = IDLE;
      ptr_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (age_tick) begin
            state_d = SWEEP;
            ptr_d   = '0;
          end
        end
        SWEEP: begin
          sweep_active = 1'b1;
          if (ptr_q == idx_t'(TABLE_ROWS - 1)) begin
            state_d = IDLE;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + idx_t'(1);
          end
        end
      endcase
    end
  end

endmodule
